// File: rtl/tdc_pkg.sv
// Shared definitions for the tapped-delay-line capture block:
// controller state encoding, flush length and count-width helper.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    ACCUM  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Two synchroniser flops plus the registered popcount stage.
  localparam int FLUSH_CYCLES = 3;

  // Bits needed to hold a ones-count of 0..n_taps inclusive.
  function automatic int count_w(input int n_taps);
    return $clog2(n_taps + 1);
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// One delay-line channel: counts set taps (order-independent, so bubbles
// in the thermometer code do not matter) and registers the result.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int CW     = count_w(N_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_TAPS-1:0] i_word,
  output logic [CW-1:0]     o_count
);

  logic [CW-1:0] w_ones;
  logic [CW-1:0] r_count;

  // Sum the individual tap bits.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      w_ones = w_ones + CW'(i_word[i]);
    end
  end

  // Register the count so the adder tree is isolated from the accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else     r_count <= w_ones;
  end

  assign o_count = r_count;

endmodule

// File: rtl/tdc_capture.sv
// Multi-channel TDC capture: synchronises raw tap levels, converts them to
// counts, accumulates 2^ACC_LOG2 samples per channel (sum/min/max) and then
// reports one result word per channel over a valid/ready handshake.
module tdc_capture
  import tdc_pkg::*;
#(
  parameter  int N_TAPS   = 16,
  parameter  int N_CH     = 2,
  parameter  int ACC_LOG2 = 3,
  localparam int CW       = count_w(N_TAPS),
  localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*N_TAPS-1:0] taps,
  input  logic                   start,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CHW-1:0]         res_ch,
  output logic [CW-1:0]          res_avg,
  output logic [CW-1:0]          res_min,
  output logic [CW-1:0]          res_max
);

  localparam int             SW         = CW + ACC_LOG2;
  localparam logic [7:0]     FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0]     ACC_LAST   = 8'((1 << ACC_LOG2) - 1);
  localparam logic [CHW-1:0] CH_LAST    = CHW'(N_CH - 1);

  logic [N_CH*N_TAPS-1:0] r_sync_p0;
  logic [N_CH*N_TAPS-1:0] r_sync_p1;
  logic [CW-1:0]          w_cnt [N_CH];

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_cnt;
  logic [CHW-1:0] r_ch;
  logic           w_xfer;

  logic [SW-1:0] r_sum [N_CH];
  logic [CW-1:0] r_min [N_CH];
  logic [CW-1:0] r_max [N_CH];
  logic [SW-1:0] w_shift;

  // Two-flop synchroniser on every tap bit; taps are asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= taps;
      r_sync_p1 <= r_sync_p0;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tdc_popcount #(
      .N_TAPS (N_TAPS),
      .CW     (CW)
    ) u_popcount (
      .clk     (clk),
      .rst     (rst),
      .i_word  (r_sync_p1[c*N_TAPS +: N_TAPS]),
      .o_count (w_cnt[c])
    );
  end

  assign w_xfer = (r_state == REPORT) && res_ready;

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: start only counts in IDLE; phases end on cycle counts.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = FLUSH;
      FLUSH:   if (r_cnt == FLUSH_LAST) w_next = ACCUM;
      ACCUM:   if (r_cnt == ACC_LAST) w_next = REPORT;
      REPORT:  if (w_xfer && (r_ch == CH_LAST)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Phase cycle counter restarts at every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_cnt <= '0;
    else if ((w_next != r_state) || (r_state == IDLE)) r_cnt <= '0;
    else                                           r_cnt <= r_cnt + 8'd1;
  end

  // Report channel pointer advances on each accepted result word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_ch <= '0;
    else if (r_state != REPORT)              r_ch <= '0;
    else if (w_xfer && (r_ch == CH_LAST))    r_ch <= '0;
    else if (w_xfer)                         r_ch <= r_ch + CHW'(1);
  end

  // Per-channel statistics: cleared while flushing, updated once per ACCUM cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        r_sum[c] <= '0;
        r_min[c] <= '0;
        r_max[c] <= '0;
      end
    end else if (r_state == FLUSH) begin
      for (int c = 0; c < N_CH; c++) begin
        r_sum[c] <= '0;
        r_min[c] <= '1;
        r_max[c] <= '0;
      end
    end else if (r_state == ACCUM) begin
      for (int c = 0; c < N_CH; c++) begin
        r_sum[c] <= r_sum[c] + SW'(w_cnt[c]);
        if (w_cnt[c] < r_min[c]) r_min[c] <= w_cnt[c];
        if (w_cnt[c] > r_max[c]) r_max[c] <= w_cnt[c];
      end
    end
  end

  // Result mux; everything reads zero outside REPORT.
  always_comb begin
    w_shift   = r_sum[r_ch] >> ACC_LOG2;
    res_valid = (r_state == REPORT);
    busy      = (r_state != IDLE);
    res_ch    = '0;
    res_avg   = '0;
    res_min   = '0;
    res_max   = '0;
    if (r_state == REPORT) begin
      res_ch  = r_ch;
      res_avg = w_shift[CW-1:0];
      res_min = r_min[r_ch];
      res_max = r_max[r_ch];
    end
  end

endmodule

// File: tb/tb_tdc_capture.sv
// Directed + randomized bench for tdc_capture with a sample-history model.
module tb_tdc_capture;

  localparam int N_TAPS   = 16;
  localparam int N_CH     = 2;
  localparam int ACC_LOG2 = 3;
  localparam int CW       = 5;
  localparam int CHW      = 1;
  localparam int NS       = 1 << ACC_LOG2;
  localparam int TW       = N_CH * N_TAPS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          res_ready = 1'b0;
  logic [TW-1:0] taps = '0;
  logic          busy;
  logic          res_valid;
  logic [CHW-1:0] res_ch;
  logic [CW-1:0] res_avg;
  logic [CW-1:0] res_min;
  logic [CW-1:0] res_max;

  int errors = 0;
  int checks = 0;
  int got_avg [N_CH];
  int got_min [N_CH];
  int got_max [N_CH];

  always #5 clk = ~clk;

  tdc_capture #(
    .N_TAPS   (N_TAPS),
    .N_CH     (N_CH),
    .ACC_LOG2 (ACC_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .taps      (taps),
    .start     (start),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ch    (res_ch),
    .res_avg   (res_avg),
    .res_min   (res_min),
    .res_max   (res_max)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tap patterns: 0 constant, 1 alternating ch0, 2 random, 3 bubble word.
  function automatic logic [TW-1:0] gen(input int mode, input int c);
    logic [TW-1:0] w;
    w = TW'({$urandom(), $urandom()});
    if ($urandom_range(0, 7) == 0) w[15:0] = '1;
    if ($urandom_range(0, 7) == 0) w[31:16] = '0;
    case (mode)
      0: begin w[15:0] = 16'h00FF; w[31:16] = 16'hFFFF; end
      1: w[15:0] = c[0] ? 16'h003F : 16'h000F;
      3: begin w[15:0] = 16'h0F0F; w[31:16] = 16'h0000; end
      default: ;
    endcase
    return w;
  endfunction

  // One full run: start, flush+accumulate, then report with optional back-pressure.
  task automatic do_run(input int mode, input int hold, input bit restart);
    logic [TW-1:0]     hist [NS+1];
    logic [TW-1:0]     w;
    logic [N_TAPS-1:0] v;
    int e_avg [N_CH];
    int e_min [N_CH];
    int e_max [N_CH];
    int s, cnt, nh;
    @(posedge clk); #1;
    start = 1'b1; res_ready = (hold == 0); taps = gen(mode, 0);
    @(negedge clk);
    chk("busy_at_start", 32'(busy), 32'd0);
    for (int c = 1; c <= 3 + NS; c++) begin
      @(posedge clk); #1;
      start = (restart && c == 6);
      w = gen(mode, c);
      taps = w;
      if (c <= NS) hist[c] = w;
      @(negedge clk);
      chk("valid_before_report", 32'(res_valid), 32'd0);
      chk("busy_running", 32'(busy), 32'd1);
      if (c == 5) chk("outputs_zero_outside_report", 32'({res_ch, res_avg, res_min, res_max}), 32'd0);
    end
    // Reference: taps seen in cycles 1..NS after start are the sampled ones.
    for (int ch = 0; ch < N_CH; ch++) begin
      s = 0; e_min[ch] = 1000; e_max[ch] = -1;
      for (int k = 1; k <= NS; k++) begin
        w = hist[k];
        v = w[ch*N_TAPS +: N_TAPS];
        cnt = $countones(v);
        s += cnt;
        if (cnt < e_min[ch]) e_min[ch] = cnt;
        if (cnt > e_max[ch]) e_max[ch] = cnt;
      end
      e_avg[ch] = s / NS;
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      nh = (ch == 0) ? hold : 0;
      for (int h = 0; h < nh; h++) begin
        @(posedge clk); #1;
        res_ready = 1'b0; taps = gen(2, 0);
        @(negedge clk);
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_ch", 32'(res_ch), 32'(ch));
        chk("hold_avg", 32'(res_avg), 32'(e_avg[ch]));
        chk("hold_min", 32'(res_min), 32'(e_min[ch]));
        chk("hold_max", 32'(res_max), 32'(e_max[ch]));
      end
      @(posedge clk); #1;
      res_ready = 1'b1; taps = gen(2, 0);
      @(negedge clk);
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_ch", 32'(res_ch), 32'(ch));
      chk("res_avg", 32'(res_avg), 32'(e_avg[ch]));
      chk("res_min", 32'(res_min), 32'(e_min[ch]));
      chk("res_max", 32'(res_max), 32'(e_max[ch]));
      got_avg[ch] = int'(res_avg);
      got_min[ch] = int'(res_min);
      got_max[ch] = int'(res_max);
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("valid_after_last", 32'(res_valid), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(res_valid), 32'd0);
    chk("reset_outputs", 32'({res_ch, res_avg, res_min, res_max}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Constant taps, ready high: back-to-back results.
    do_run(0, 0, 1'b0);
    chk("const_ch0_avg", 32'(got_avg[0]), 32'd8);
    chk("const_ch0_min", 32'(got_min[0]), 32'd8);
    chk("const_ch0_max", 32'(got_max[0]), 32'd8);
    chk("const_ch1_avg", 32'(got_avg[1]), 32'd16);
    chk("const_ch1_min", 32'(got_min[1]), 32'd16);
    chk("const_ch1_max", 32'(got_max[1]), 32'd16);

    // Alternating 0x000F / 0x003F on ch0.
    do_run(1, 0, 1'b0);
    chk("alt_ch0_avg", 32'(got_avg[0]), 32'd5);
    chk("alt_ch0_min", 32'(got_min[0]), 32'd4);
    chk("alt_ch0_max", 32'(got_max[0]), 32'd6);

    // Back-pressure for 5 cycles on the first word.
    do_run(2, 5, 1'b0);

    // Second start during ACCUM is ignored: no extra results afterwards.
    do_run(2, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_extra_result", 32'(res_valid), 32'd0);
    end

    // Bubble word.
    do_run(3, 0, 1'b0);
    chk("bubble_ch0_avg", 32'(got_avg[0]), 32'd8);
    chk("bubble_ch1_max", 32'(got_max[1]), 32'd0);

    // Reset during ACCUM discards the run.
    @(posedge clk); #1;
    start = 1'b1; taps = gen(2, 0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0; taps = gen(2, c);
    end
    rst = 1'b1;
    #1;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_idle_valid", 32'(res_valid), 32'd0);
    end
    chk("post_reset_idle_busy", 32'(busy), 32'd0);
    do_run(2, 0, 1'b0);

    // Random runs with random back-pressure.
    for (int r = 0; r < 6; r++) begin
      do_run(2, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
